// File: rtl/mem_access_stage.sv
// Memory stage: performs data-memory loads and stores over a req/ack bus, stalls the
// upstream pipeline while an access is outstanding, and registers the MEM/WB result.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_we_in,
  input  logic        mem_we_in,
  input  logic        mem_to_reg_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_access;
  logic          w_misaligned;
  logic          w_timeout;
  logic          w_stall;

  assign w_access     = mem_we_in | mem_to_reg_in;
  assign w_misaligned = (alu_res_in[1:0] != 2'b00);
  assign w_timeout    = (r_cnt == CNT_LAST);
  assign stall        = w_stall;

  // Freeze upstream while a request is pending and not yet resolved this cycle
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_misaligned) w_stall = 1'b1;
        else                           w_stall = 1'b0;
      end
      S_WAIT: begin
        if (!dmem_ack && !w_timeout) w_stall = 1'b1;
        else                         w_stall = 1'b0;
      end
      default: w_stall = 1'b0;
    endcase
  end

  // Access FSM with registered bus and MEM/WB outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0000_0000;
      dmem_wdata  <= 32'h0000_0000;
      wb_data_out <= 32'h0000_0000;
      rd_out      <= 5'd0;
      reg_we_out  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= {CW{1'b0}};
          if (!w_access) begin
            wb_data_out <= alu_res_in;
            rd_out      <= rd_in;
            reg_we_out  <= reg_we_in;
            fault       <= 1'b0;
          end else if (w_misaligned) begin
            reg_we_out <= 1'b0;
            fault      <= 1'b1;
          end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_we_in;
            dmem_addr  <= {alu_res_in[31:2], 2'b00};
            dmem_wdata <= rd2_in;
            reg_we_out <= 1'b0;
            fault      <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            // dmem_we still holds the captured direction of this transaction
            dmem_req    <= 1'b0;
            wb_data_out <= dmem_we ? alu_res_in : dmem_rdata;
            rd_out      <= rd_in;
            reg_we_out  <= reg_we_in;
            fault       <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            dmem_req   <= 1'b0;
            reg_we_out <= 1'b0;
            fault      <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt      <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            reg_we_out <= 1'b0;
            fault      <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          dmem_req   <= 1'b0;
          reg_we_out <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected MEM/WB results and fault
// pulses into queues, and a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu_res_in = 32'h0;
  logic [31:0] rd2_in = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic        reg_we_in = 1'b0;
  logic        mem_we_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        reg_we_out;
  logic        fault;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  logic [36:0] exp_q[$];
  int          fault_q[$];

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .alu_res_in(alu_res_in), .rd2_in(rd2_in), .rd_in(rd_in),
    .reg_we_in(reg_we_in), .mem_we_in(mem_we_in), .mem_to_reg_in(mem_to_reg_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_data_out(wb_data_out), .rd_out(rd_out), .reg_we_out(reg_we_out), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts stall/req cycles and scores every MEM/WB write and fault pulse
  always @(negedge clk) begin
    if (reset) begin
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (reg_we_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 32'(rd_out), 32'hFFFF_FFFF);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("wb_data", wb_data_out, e[31:0]);
          chk("rd_out", 32'(rd_out), 32'(e[36:32]));
        end
      end
      if (fault) begin
        if (fault_q.size() == 0) chk("unexpected_fault", 32'(fault), 32'h0);
        else void'(fault_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    alu_res_in = 32'h0; rd2_in = 32'h0; rd_in = 5'd0;
    reg_we_in = 1'b0; mem_we_in = 1'b0; mem_to_reg_in = 1'b0;
  endtask

  task automatic passthru(input logic [31:0] val, input logic [4:0] rd, input logic ack);
    @(posedge clk); #1;
    alu_res_in = val; rd_in = rd; reg_we_in = 1'b1;
    dmem_ack = ack; dmem_rdata = 32'hBAD0_BAD0;
    exp_q.push_back({rd, val});
    @(negedge clk);
    chk("pass_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    clear_inputs(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("pass_no_req", 32'(dmem_req), 32'h0);
  endtask

  // k = WAIT cycle (1-based) in which the ack is presented
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic st,
                           input logic [4:0] rd, input logic [31:0] rdata, input int k);
    int s0;
    @(posedge clk); #1;
    alu_res_in = addr; rd2_in = wdata; mem_we_in = st; mem_to_reg_in = ~st;
    rd_in = rd; reg_we_in = 1'b1;
    exp_q.push_back({rd, st ? addr : rdata});
    s0 = stall_cnt;
    @(posedge clk); #1;
    chk("req_rise", 32'(dmem_req), 32'h1);
    chk("req_we", 32'(dmem_we), 32'(st));
    chk("req_addr", dmem_addr, addr);
    if (st) chk("req_wdata", dmem_wdata, wdata);
    for (int i = 1; i < k; i++) begin
      @(posedge clk); #1;
      chk("req_hold", 32'(dmem_req), 32'h1);
      chk("addr_hold", dmem_addr, addr);
      if (st) chk("wdata_hold", dmem_wdata, wdata);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    clear_inputs();
    chk("stall_cycles", 32'(stall_cnt - s0), 32'(k));
    chk("req_fall", 32'(dmem_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int r0;
    #3;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wb", wb_data_out, 32'h0);
    chk("rst_rd", 32'(rd_out), 32'h0);
    chk("rst_regwe", 32'(reg_we_out), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    passthru(32'h0000_1234, 5'd5, 1'b0);
    passthru(32'hDEAD_BEEF, 5'd0, 1'b1);   // x0 destination, stray ack in IDLE

    do_access(32'h0000_0100, 32'h0, 1'b0, 5'd3, 32'hCAFE_F00D, 1);
    do_access(32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 5'd7, 32'h0, 3);

    // misaligned load is dropped with a fault
    @(posedge clk); #1;
    alu_res_in = 32'h0000_0102; mem_to_reg_in = 1'b1; rd_in = 5'd6; reg_we_in = 1'b1;
    fault_q.push_back(1);
    r0 = req_cnt;
    @(negedge clk);
    chk("mis_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    clear_inputs();
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_regwe", 32'(reg_we_out), 32'h0);
    @(posedge clk); #1;
    chk("mis_fault_pulse", 32'(fault), 32'h0);
    chk("mis_no_req", 32'(req_cnt - r0), 32'h0);

    // timeout with TIMEOUT=4
    @(posedge clk); #1;
    alu_res_in = 32'h0000_0300; mem_to_reg_in = 1'b1; rd_in = 5'd9; reg_we_in = 1'b1;
    fault_q.push_back(1);
    s0 = stall_cnt; r0 = req_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("to_still_req", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    clear_inputs();
    chk("to_stall_cycles", 32'(stall_cnt - s0), 32'h4);
    chk("to_req_cycles", 32'(req_cnt - r0), 32'h4);
    chk("to_req_fall", 32'(dmem_req), 32'h0);
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_regwe", 32'(reg_we_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("late_ack_req", 32'(dmem_req), 32'h0);
    chk("late_ack_regwe", 32'(reg_we_out), 32'h0);
    chk("late_ack_stall", 32'(stall), 32'h0);

    // asynchronous reset mid-WAIT
    @(posedge clk); #1;
    alu_res_in = 32'h0000_0400; mem_to_reg_in = 1'b1; rd_in = 5'd2; reg_we_in = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(dmem_req), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(dmem_req), 32'h0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    do_access(32'h0000_0404, 32'h0, 1'b0, 5'd4, 32'h1234_5678, 2);
    do_access(32'h0000_0408, 32'h5555_AAAA, 1'b1, 5'd8, 32'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("fault_q_drained", 32'(fault_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
